// File: rtl/mfp_ahb_lite_sram_pipe.sv
// rtl/mfp_ahb_lite_sram_pipe.sv - AHB-Lite slave front end for a 1R/1W synchronous RAM
//
// Purpose:
//   Turns AHB-Lite address phases into RAM read/write strobes with byte-lane
//   masks. Reads issue in the address phase. Writes are registered and issue
//   in the data phase together with HWDATA. A read that lands on the word
//   being written in the same cycle gets the in-flight bytes merged into its
//   returned data. READ_LATENCY-1 wait states are inserted on reads. Illegal
//   transfers (oversize or misaligned) get the two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HSEL, HADDR, HSIZE,   AHB-Lite address phase
//   HTRANS, HWRITE, HREADY
//   HWDATA                AHB-Lite write data (data phase)
//   HRDATA, HREADYOUT,    AHB-Lite slave response
//   HRESP
//   ram_re, ram_raddr,    RAM read port (data READ_LATENCY cycles after ram_re)
//   ram_rdata
//   ram_we, ram_waddr,    RAM write port
//   ram_wmask, ram_wdata

module mfp_ahb_lite_sram_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                                        HCLK,
  input  logic                                        HRESETn,
  input  logic                                        HSEL,
  input  logic [ADDR_WIDTH-1:0]                       HADDR,
  input  logic [2:0]                                  HSIZE,
  input  logic [1:0]                                  HTRANS,
  input  logic                                        HWRITE,
  input  logic                                        HREADY,
  input  logic [DATA_WIDTH-1:0]                       HWDATA,
  output logic [DATA_WIDTH-1:0]                       HRDATA,
  output logic                                        HREADYOUT,
  output logic                                        HRESP,
  output logic                                        ram_re,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  ram_raddr,
  input  logic [DATA_WIDTH-1:0]                       ram_rdata,
  output logic                                        ram_we,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  ram_waddr,
  output logic [DATA_WIDTH/8-1:0]                     ram_wmask,
  output logic [DATA_WIDTH-1:0]                       ram_wdata
);

  localparam int L   = DATA_WIDTH / 8;
  localparam int B   = $clog2(L);
  localparam int WAW = ADDR_WIDTH - B;

  localparam logic [1:0]   CNT_LOAD = 2'(READ_LATENCY - 1);
  localparam logic [2:0]   MAX_SIZE = 3'(B);
  localparam logic [B:0]   ONE_NB   = 1;
  localparam logic [B-1:0] ONE_OFF  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RWAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;

  logic           r_wpend;
  logic [WAW-1:0] r_waddr;
  logic [L-1:0]   r_wmask;

  logic [L-1:0]          r_fwd_mask;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  logic           w_accept;
  logic           w_size_ok;
  logic [B:0]     w_nbytes;
  logic [B-1:0]   w_offset;
  logic           w_aligned;
  logic           w_legal;
  logic [L-1:0]   w_mask;
  logic [WAW-1:0] w_word;
  logic           w_rd_acc;
  logic           w_wr_acc;
  logic           w_err_acc;
  logic           w_fwd_hit;
  logic           w_take;
  logic           w_unused;

  // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY; both pairs behave alike here.
  assign w_unused = HTRANS[0];

  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_word   = HADDR[ADDR_WIDTH-1:B];

  // Size/alignment check and lane mask.
  always_comb begin
    w_size_ok = (HSIZE <= MAX_SIZE);
    // Clamp the shift when the size is out of range; the transfer is illegal anyway.
    w_nbytes  = w_size_ok ? (ONE_NB << HSIZE) : ONE_NB;
    w_offset  = HADDR[B-1:0];
    // For a full-width transfer w_nbytes[B-1:0] is 0, so the mask becomes all ones.
    w_aligned = ((w_offset & (w_nbytes[B-1:0] - ONE_OFF)) == '0);
    w_legal   = w_size_ok & w_aligned;
    w_mask    = '0;
    for (int i = 0; i < L; i++) begin
      if (w_legal && (i >= int'(w_offset)) && (i < int'(w_offset) + int'(w_nbytes))) begin
        w_mask[i] = 1'b1;
      end
    end
  end

  assign w_rd_acc  = w_accept & ~HWRITE & w_legal;
  assign w_wr_acc  = w_accept & HWRITE & w_legal;
  assign w_err_acc = w_accept & ~w_legal;

  // Read in the same cycle as the data phase of a write to the same word.
  assign w_fwd_hit = w_rd_acc & r_wpend & (r_waddr == w_word);

  assign ram_re    = w_rd_acc;
  assign ram_raddr = w_word;

  assign ram_we    = r_wpend;
  assign ram_waddr = r_waddr;
  assign ram_wmask = r_wmask;
  assign ram_wdata = HWDATA;

  // Write address phase capture; data phase follows in the next cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wpend <= 1'b0;
      r_wmask <= '0;
      r_waddr <= '0;
    end else begin
      r_wpend <= w_wr_acc;
      r_wmask <= w_wr_acc ? w_mask : '0;
      if (w_wr_acc) begin
        r_waddr <= w_word;
      end
    end
  end

  // Forwarding capture, held until the read data phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else if (w_rd_acc) begin
      r_fwd_mask <= w_fwd_hit ? r_wmask : '0;
      r_fwd_data <= HWDATA;
    end
  end

  always_comb begin
    HRDATA = ram_rdata;
    for (int i = 0; i < L; i++) begin
      if (r_fwd_mask[i]) begin
        HRDATA[8*i +: 8] = r_fwd_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_take = 1'b1;
      end
      S_RWAIT: begin
        if (r_cnt != 2'd0) begin
          HREADYOUT = 1'b0;
          w_cnt_nxt = r_cnt - 2'd1;
        end else begin
          w_take = 1'b1;
        end
      end
      S_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = S_ERR2;
      end
      S_ERR2: begin
        HRESP  = 1'b1;
        w_take = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Any cycle that completes a data phase may start the next transfer.
    if (w_take) begin
      w_state_nxt = S_IDLE;
      if (w_err_acc) begin
        w_state_nxt = S_ERR1;
      end else if (w_rd_acc && (READ_LATENCY > 1)) begin
        w_state_nxt = S_RWAIT;
        w_cnt_nxt   = CNT_LOAD;
      end
    end
  end

endmodule
